// File: rtl/keypad_debounce_array.sv
// N-channel key debouncer: per-channel 2-flop sync + debounce FSM, pended press/release
// events drained lowest-index-first through a valid/ready port. DEBOUNCE_AUTOREPEAT_EN adds typematic repeat.
module keypad_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 960000,
`ifdef DEBOUNCE_AUTOREPEAT_EN
  parameter int REPEAT_DELAY    = 24000000,
  parameter int REPEAT_PERIOD   = 4800000,
`endif
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic ev,
  output logic ev_press
);
  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  assign s      = sync_q[1];
  assign stable = (state == HELD) || (state == DB_RELEASE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      state  <= IDLE;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      state  <= state_nxt;
      cnt    <= cnt_nxt;
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  // Set on every entry to HELD so the first repeat waits the long delay.
  logic rep_first, rep_first_nxt;

  always_ff @(posedge clk) begin
    if (reset) rep_first <= 1'b1;
    else       rep_first <= rep_first_nxt;
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ev        = 1'b0;
    ev_press  = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    rep_first_nxt = (state == HELD) ? rep_first : 1'b1;
`endif
    case (state)
      IDLE:
        if (s) begin
          state_nxt = DB_PRESS;
          cnt_nxt   = '0;
        end
      DB_PRESS:
        if (!s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          ev        = 1'b1;
          ev_press  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      HELD:
        if (!s) begin
          state_nxt = DB_RELEASE;
          cnt_nxt   = '0;
        end
`ifdef DEBOUNCE_AUTOREPEAT_EN
        else if (cnt == (rep_first ? RD_LAST : RP_LAST)) begin
          cnt_nxt       = '0;
          ev            = 1'b1;
          ev_press      = 1'b1;
          rep_first_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      DB_RELEASE:
        if (s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          ev        = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end
endmodule

module keypad_debounce_array #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 960000,
  parameter int REPEAT_DELAY    = 24000000,
  parameter int REPEAT_PERIOD   = 4800000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  raw,
  output logic [N_CH-1:0]  stable,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [$clog2(N_CH)-1:0] ev_ch,
  output logic             ev_press,
  output logic             overrun
);
  localparam int IDX_W = $clog2(N_CH);
  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CNT_W = $clog2(MAX_C) + 1;

  logic [N_CH-1:0]  ch_ev, ch_press;
  logic [N_CH-1:0]  pend, pend_type, take;
  logic [IDX_W-1:0] sel;
  logic             load;

  keypad_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef DEBOUNCE_AUTOREPEAT_EN
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
`endif
    .CNT_W          (CNT_W)
  ) u_ch [N_CH-1:0] (
    .clk     (clk),
    .reset   (reset),
    .raw     (raw),
    .stable  (stable),
    .ev      (ch_ev),
    .ev_press(ch_press)
  );

  assign load = !ev_valid || ev_ready;

  // Lowest-index pending channel wins the output register.
  always_comb begin
    sel  = '0;
    take = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (pend[i]) sel = IDX_W'(i);
    if (load && (|pend)) take[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= '0;
      pend_type <= '0;
      ev_valid  <= 1'b0;
      ev_ch     <= '0;
      ev_press  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pend      <= ch_ev | (pend & ~take);
      pend_type <= (ch_ev & ch_press) | (~ch_ev & pend_type);
      // A slot being emitted this cycle is free, so refilling it is not an overrun.
      if (|(ch_ev & pend & ~take)) overrun <= 1'b1;
      if (load) begin
        ev_valid <= |pend;
        if (|pend) begin
          ev_ch    <= sel;
          ev_press <= pend_type[sel];
        end
      end
    end
  end
endmodule

// File: tb/tb_keypad_debounce_array.sv
// Bench for keypad_debounce_array: directed table + hand sequences + random stimulus
// checked every cycle against a run-length/event-list reference model.
module tb_keypad_debounce_array;
  localparam int N_CH = 4;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 5;

  logic             clk;
  logic             reset;
  logic [N_CH-1:0]  raw;
  logic [N_CH-1:0]  stable;
  logic             ev_valid;
  logic             ev_ready;
  logic [1:0]       ev_ch;
  logic             ev_press;
  logic             overrun;

  keypad_debounce_array #(
    .N_CH(N_CH), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .raw(raw), .stable(stable), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_ch(ev_ch), .ev_press(ev_press), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit mchk_en  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a level flips after DB+1 consecutive synchronised samples that
  // disagree with it; events sit in a per-channel slot (-1 = empty) until emitted.
  bit         m_lvl [N_CH];
  int         m_run [N_CH];
  int         m_age [N_CH];
  bit         m_h1  [N_CH];
  bit         m_h2  [N_CH];
  int         m_pend[N_CH];
  bit         m_vld, m_prs, m_ovr;
  logic [1:0] m_ch;

  task automatic model_step();
    int ev [N_CH];
    int sel;
    bit s;
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        m_lvl[i] = 0; m_run[i] = 0; m_age[i] = 0; m_h1[i] = 0; m_h2[i] = 0; m_pend[i] = -1;
      end
      m_vld = 0; m_prs = 0; m_ovr = 0; m_ch = 0;
      return;
    end
    for (int i = 0; i < N_CH; i++) begin
      s = m_h2[i];
      m_h2[i] = m_h1[i];
      m_h1[i] = raw[i];
      ev[i] = -1;
      if (s != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB + 1) begin
          m_lvl[i] = s; m_run[i] = 0; m_age[i] = 0; ev[i] = int'(s);
        end
      end else begin
        if (m_run[i] != 0) m_age[i] = 0;
        else if (m_lvl[i]) begin
          m_age[i]++;
`ifdef DEBOUNCE_AUTOREPEAT_EN
          if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0)) ev[i] = 1;
`endif
        end
        m_run[i] = 0;
      end
    end
    if (!m_vld || ev_ready) begin
      sel = -1;
      for (int i = N_CH - 1; i >= 0; i--) if (m_pend[i] >= 0) sel = i;
      m_vld = (sel >= 0);
      if (sel >= 0) begin
        m_ch = 2'(sel); m_prs = (m_pend[sel] == 1); m_pend[sel] = -1;
      end
    end
    for (int i = 0; i < N_CH; i++)
      if (ev[i] >= 0) begin
        if (m_pend[i] >= 0) m_ovr = 1;
        m_pend[i] = ev[i];
      end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [N_CH-1:0] lv;
    @(negedge clk);
    if (mchk_en) begin
      for (int i = 0; i < N_CH; i++) lv[i] = m_lvl[i];
      chk("model_stable", 32'(stable), 32'(lv));
      chk("model_valid", 32'(ev_valid), 32'(m_vld));
      if (m_vld) chk("model_event", 32'({ev_ch, ev_press}), 32'({m_ch, m_prs}));
      chk("model_overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  typedef struct {
    int              n;
    logic [N_CH-1:0] raw;
    logic            rdy;
    logic [N_CH-1:0] stb;
    logic            vld;
    logic [1:0]      ch;
    logic            prs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int n, logic [3:0] r, logic rd, logic [3:0] sb, logic v,
                              logic [1:0] c, logic p);
    vec_t x;
    x.n = n; x.raw = r; x.rdy = rd; x.stb = sb; x.vld = v; x.ch = c; x.prs = p;
    return x;
  endfunction

  task automatic chk_evt(input string nm, input logic [1:0] c, input logic p);
    chk({nm, "_valid"}, 32'(ev_valid), 32'd1);
    chk({nm, "_event"}, 32'({ev_ch, ev_press}), 32'({c, p}));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  int rep_exp[4] = '{8, 18, 23, 28};

  initial begin
    raw = '0; ev_ready = 1'b0; reset = 1'b1;
    cyc(3);
    chk("reset_stable", 32'(stable), 32'd0);
    chk("reset_valid", 32'(ev_valid), 32'd0);
    chk("reset_ch", 32'(ev_ch), 32'd0);
    chk("reset_press", 32'(ev_press), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    mchk_en = 1;
    reset = 1'b0;
    cyc(3);

    // Clean press/release of ch1 with ready high, then a short bounce on ch0.
    tbl.push_back(mk(6,  4'b0010, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1,  4'b0010, 1, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(1,  4'b0010, 1, 4'b0010, 1, 1, 1));
    tbl.push_back(mk(1,  4'b0010, 1, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(11, 4'b0010, 1, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(6,  4'b0000, 1, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(1,  4'b0000, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1,  4'b0000, 1, 4'b0000, 1, 1, 0));
    tbl.push_back(mk(1,  4'b0000, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(3,  4'b0001, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(10, 4'b0000, 1, 4'b0000, 0, 0, 0));
    foreach (tbl[k]) begin
      raw = tbl[k].raw; ev_ready = tbl[k].rdy;
      cyc(tbl[k].n);
      chk("tbl_stable", 32'(stable), 32'(tbl[k].stb));
      chk("tbl_valid", 32'(ev_valid), 32'(tbl[k].vld));
      if (tbl[k].vld) chk("tbl_event", 32'({ev_ch, ev_press}), 32'({tbl[k].ch, tbl[k].prs}));
    end
    chk("tbl_overrun", 32'(overrun), 32'd0);

    // Simultaneous press of ch0 and ch2 with consumer stalled.
    raw = 4'b0101; ev_ready = 1'b0;
    cyc(7);
    chk("sim_stable", 32'(stable), 32'b0101);
    chk("sim_early", 32'(ev_valid), 32'd0);
    cyc(1);
    chk_evt("sim_first", 2'd0, 1'b1);
    for (int t = 0; t < 10; t++) begin
      cyc(1);
      chk_evt("sim_hold", 2'd0, 1'b1);
    end
    ev_ready = 1'b1;
    cyc(1);
    ev_ready = 1'b0;
    chk_evt("sim_second", 2'd2, 1'b1);
    ev_ready = 1'b1;
    cyc(1);
    chk("sim_drained", 32'(ev_valid), 32'd0);
    chk("sim_overrun", 32'(overrun), 32'd0);
    raw = 4'b0000;
    cyc(12);

    // Overrun: ch0 parked, ch3 press then release overwrite its slot.
    pulse_reset();
    raw = 4'b0001; ev_ready = 1'b0;
    cyc(8);
    chk_evt("ovr_park", 2'd0, 1'b1);
    raw = 4'b1001;
    cyc(8);
    chk("ovr_none_yet", 32'(overrun), 32'd0);
    raw = 4'b0001;
    cyc(8);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk_evt("ovr_still_parked", 2'd0, 1'b1);
    ev_ready = 1'b1;
    cyc(1);
    chk_evt("ovr_next", 2'd3, 1'b0);
    cyc(1);
    chk("ovr_empty", 32'(ev_valid), 32'd0);
    raw = 4'b0000;
    cyc(10);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-debounce with an event parked and raw[1] held.
    pulse_reset();
    raw = 4'b0001; ev_ready = 1'b0;
    cyc(8);
    chk_evt("rst_park", 2'd0, 1'b1);
    raw = 4'b0011;
    cyc(4);
    reset = 1'b1; raw = 4'b0010;
    cyc(1);
    chk("rst_stable", 32'(stable), 32'd0);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_ch", 32'(ev_ch), 32'd0);
    chk("rst_press", 32'(ev_press), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0; ev_ready = 1'b1;
    cyc(6);
    chk("rst_stable_early", 32'(stable), 32'd0);
    cyc(1);
    chk("rst_stable_up", 32'(stable), 32'b0010);
    cyc(1);
    chk_evt("rst_reemerge", 2'd1, 1'b1);
    raw = 4'b0000;
    cyc(12);

`ifdef DEBOUNCE_AUTOREPEAT_EN
    begin
      int np;
      np = 0;
      raw = 4'b0010; ev_ready = 1'b1;
      for (int t = 1; t <= 60; t++) begin
        if (t == 28) raw = 4'b0000;
        cyc(1);
        if (ev_valid && ev_press) begin
          chk("rep_ch", 32'(ev_ch), 32'd1);
          if (np < 4) chk("rep_step", 32'(t), 32'(rep_exp[np]));
          else chk("rep_extra", 32'(t), 32'd0);
          np++;
        end
      end
      chk("rep_count", 32'(np), 32'd4);
    end
`endif

    // Random keys with bursty bounce and a randomly stalling consumer.
    for (int blk = 0; blk < 15; blk++) begin
      int p;
      p = (blk % 2 != 0) ? 3 : 12;
      for (int t = 0; t < 200; t++) begin
        for (int i = 0; i < N_CH; i++)
          if ($urandom_range(0, p - 1) == 0) raw[i] = ~raw[i];
        ev_ready = ($urandom_range(0, 3) != 0);
        cyc(1);
      end
    end
    raw = '0; ev_ready = 1'b1;
    cyc(20);
    chk("final_idle", 32'(ev_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
